ecall_controller: RTL and testbench
===================================

# ecall_controller

Sequencer for RISC-V `ecall` (instruction word 32'h00000073) in the single-cycle core. It detects an `ecall`, decodes the service code in a7 (x17), and stalls the PC/pipeline while the service runs. Services are print-integer, read-integer and exit. For read-integer it takes the register-file write port and writes the result into a0 (x10).

## Interface
Parameters:
- `SW_W`, 16: width of switch input; zero-extended to 32 bits on read.

Ports:
- `clk`  in  1: core clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-low; low clears all state immediately.
- `instruction`  in  32: current instruction word from fetch.
- `a7`  in  32: register-file x17 value.
- `a0`  in  32: register-file x10 value (second read port during `ecall`).
- `switch_in`  in  SW_W: user switches, quasi-static.
- `confirm`  in  1: user button, asynchronous level.
- `stall`  out  1: high freezes PC and blocks core register writes.
- `rf_wen`  out  1: write-port override enable to the register file.
- `rf_waddr`  out  5: override write address, always 5'd10 when `rf_wen`.
- `rf_wdata`  out  32: override write data.
- `disp_data`  out  32: value to show on the 7-segment driver; retained.
- `disp_valid`  out  1: high while a print is waiting for acknowledge.
- `halt`  out  1: program finished; sticky until reset.

## Operation
- States: IDLE, PRINT_WAIT, READ_WAIT, WRITEBACK, RELEASE, HALT.
- `ecall_hit` = (instruction == 32'h00000073) and state == IDLE.
- In IDLE, `stall` = `ecall_hit` and a7 ∈ {1, 5, 10}. This is a combinational path, so the `ecall` cycle is already stalled.
- a7 is compared at full 32 bits. Any other value is a no-op: no stall, and the `ecall` retires as a nop.
- IDLE, a7=1: latch a0 into `disp_data`, then go to PRINT_WAIT.
- IDLE, a7=5: go to READ_WAIT.
- IDLE, a7=10: go to HALT.
- PRINT_WAIT: `stall`=1, `disp_valid`=1. On `confirm_rise`, go to RELEASE.
- READ_WAIT: `stall`=1. On `confirm_rise`, capture {zeros, switch_in} into the data register, then go to WRITEBACK.
- WRITEBACK: one cycle with `stall`=1, `rf_wen`=1, `rf_waddr`=10, `rf_wdata`=captured value. Then go to RELEASE.
- RELEASE: one cycle with `stall`=0, so the `ecall` retires at this edge. Then go to IDLE. An `ecall` still visible during RELEASE must not retrigger, because `ecall_hit` requires IDLE.
- HALT: `stall`=1, `halt`=1 until reset. `confirm` is ignored.
- `confirm_rise` is a single-cycle pulse from a 2-flop synchronizer plus edge detect. A button already held when a wait state is entered produces no edge; a new press is required.
- `confirm_rise` is ignored outside PRINT_WAIT and READ_WAIT.
- `rf_wen` is never asserted in any state other than WRITEBACK.

## Timing
- Reset low: state=IDLE; `stall`, `rf_wen`, `disp_valid`, `halt`=0; `disp_data`=0; `rf_wdata`=0; `rf_waddr`=10; synchronizer flops=0.
- Reset is asynchronous on assert and released synchronously by the system. The first valid `ecall` is seen on the first edge after release.
- Reset mid-service: the FSM aborts, no register write occurs, and outputs take reset values immediately.
- `ecall` presented in cycle 0 with a7=5: `stall` is high in cycle 0, and state=READ_WAIT from edge 1.
- `confirm` sampled high at edge k: `confirm_rise` is high in the cycle after edge k+1, and the state changes at edge k+2.
- Read path, from that state change: WRITEBACK for 1 cycle, RELEASE for 1 cycle, then IDLE. Register x10 is updated at the WRITEBACK→RELEASE edge.
- `disp_data` changes only on an a7=1 entry; it holds across other services and HALT.

## Structure
- Shared header `ecall_defs.vh` holds:
  - state encodings (3-bit);
  - service codes SYS_PRINT_INT=1, SYS_READ_INT=5, SYS_EXIT=10;
  - ECALL_WORD=32'h00000073;
  - REG_A0=5'd10 and REG_A7=5'd17.
- Sub-module `btn_sync_edge` (clk, reset, async_in → rise): 2-flop synchronizer plus edge detect, with the same active-low asynchronous reset.
- The top level muxes core writeback with the `rf_*` overrides and gates core `regWrite` with `!stall`.

## Test plan
- Reset asserted mid-READ_WAIT, then released → state IDLE, all outputs at reset values, x10 not written.
- a7=5, `switch_in`=16'h00A5, `confirm` pulsed for 3 cycles → exactly one `rf_wen` cycle with `rf_waddr`=10 and `rf_wdata`=32'h000000A5; `stall` deasserts after WRITEBACK.
- a7=1, a0=32'hFFFFFFF6 → `disp_data`=32'hFFFFFFF6 and `disp_valid`=1 until a press; no `rf_wen` at any point.
- `confirm` held high before `ecall` a7=5 → no capture until release and re-press; the captured value is the switches at the re-press.
- a7=10 → `halt`=1 and `stall`=1 for 1000 cycles despite `confirm` toggling.
- a7=7 → `stall` stays 0, the instruction retires, state remains IDLE.

Source files
------------

// File: rtl/ecall_controller_pkg.sv
// rtl/ecall_controller_pkg.sv - shared state encodings, service codes and register indices
package ecall_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRINT_WAIT = 3'd1,
        ST_READ_WAIT  = 3'd2,
        ST_WRITEBACK  = 3'd3,
        ST_RELEASE    = 3'd4,
        ST_HALT       = 3'd5
    } state_e;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_READ_INT  = 32'd5;
    localparam logic [31:0] SYS_EXIT      = 32'd10;
    localparam logic [31:0] ECALL_WORD    = 32'h0000_0073;
    localparam logic [4:0]  REG_A0        = 5'd10;
    localparam logic [4:0]  REG_A7        = 5'd17;

    // Only these a7 values stall; anything else lets the ecall retire as a nop.
    function automatic logic is_service(input logic [31:0] code);
        return (code == SYS_PRINT_INT) || (code == SYS_READ_INT) || (code == SYS_EXIT);
    endfunction

endpackage

// File: rtl/ecall_controller_btn_sync_edge.sv
// rtl/ecall_controller_btn_sync_edge.sv - two-flop button synchronizer with rising-edge pulse
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // A button already held produces no pulse; only a fresh 0->1 transition does.
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ecall_controller.sv
// rtl/ecall_controller.sv - ecall sequencer for print-int, read-int and exit services
module ecall_controller
    import ecall_controller_pkg::*;
#(
    parameter int SW_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic [31:0]     a7,
    input  logic [31:0]     a0,
    input  logic [SW_W-1:0] switch_in,
    input  logic            confirm,
    output logic            stall,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [31:0]     rf_wdata,
    output logic [31:0]     disp_data,
    output logic            disp_valid,
    output logic            halt
);

    state_e      state_q;
    logic        stall_q;
    logic        rf_wen_q;
    logic        disp_valid_q;
    logic        halt_q;
    logic [31:0] disp_data_q;
    logic [31:0] data_q;

    logic        confirm_rise;
    logic        ecall_hit;
    logic        svc_req;

    btn_sync_edge u_btn_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .async_in (confirm),
        .rise     (confirm_rise)
    );

    assign ecall_hit = (instruction == ECALL_WORD) && (state_q == ST_IDLE);
    assign svc_req   = ecall_hit && is_service(a7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            stall_q      <= 1'b0;
            rf_wen_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            halt_q       <= 1'b0;
            disp_data_q  <= 32'd0;
            data_q       <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ecall_hit) begin
                        if (a7 == SYS_PRINT_INT) begin
                            disp_data_q  <= a0;
                            disp_valid_q <= 1'b1;
                            stall_q      <= 1'b1;
                            state_q      <= ST_PRINT_WAIT;
                        end else if (a7 == SYS_READ_INT) begin
                            stall_q <= 1'b1;
                            state_q <= ST_READ_WAIT;
                        end else if (a7 == SYS_EXIT) begin
                            stall_q <= 1'b1;
                            halt_q  <= 1'b1;
                            state_q <= ST_HALT;
                        end
                    end
                end
                ST_PRINT_WAIT: begin
                    if (confirm_rise) begin
                        disp_valid_q <= 1'b0;
                        stall_q      <= 1'b0;
                        state_q      <= ST_RELEASE;
                    end
                end
                ST_READ_WAIT: begin
                    if (confirm_rise) begin
                        data_q   <= 32'(switch_in);
                        rf_wen_q <= 1'b1;
                        state_q  <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    rf_wen_q <= 1'b0;
                    stall_q  <= 1'b0;
                    state_q  <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                ST_HALT: begin
                    stall_q <= 1'b1;
                    halt_q  <= 1'b1;
                end
                default: begin
                    stall_q      <= 1'b0;
                    rf_wen_q     <= 1'b0;
                    disp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    // The ecall cycle itself must already be frozen, hence the combinational term.
    assign stall      = stall_q | svc_req;
    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = REG_A0;
    assign rf_wdata   = data_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign halt       = halt_q;

endmodule

// File: tb/tb_ecall_controller.sv
// tb/tb_ecall_controller.sv - self-checking bench for ecall_controller
module tb_ecall_controller;

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] a7;
    logic [31:0] a0;
    logic [15:0] switch_in;
    logic        confirm;
    logic        stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        halt;

    int          total = 0;
    int          bad = 0;
    int          wen_seen = 0;
    int          hold_left = 0;
    logic [31:0] rf_model [32];
    logic [31:0] disp_model;

    ecall_controller #(.SW_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .a7          (a7),
        .a0          (a0),
        .switch_in   (switch_in),
        .confirm     (confirm),
        .stall       (stall),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the register-file model commits whatever override is presented.
    task automatic step();
        @(posedge clk);
        #2;
        if (rf_wen === 1'b1) begin
            wen_seen++;
            chk("rf_waddr", {27'd0, rf_waddr}, 32'd10);
            rf_model[rf_waddr] = rf_wdata;
        end
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) confirm = 1'b0;
        end
    endtask

    task automatic expect_outs(input string tag, input logic e_stall, input logic e_wen,
                               input logic e_dv, input logic e_halt);
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
        chk({tag, ".rf_wen"}, {31'd0, rf_wen}, {31'd0, e_wen});
        chk({tag, ".disp_valid"}, {31'd0, disp_valid}, {31'd0, e_dv});
        chk({tag, ".halt"}, {31'd0, halt}, {31'd0, e_halt});
        chk({tag, ".disp_data"}, disp_data, disp_model);
    endtask

    task automatic settle_idle();
        confirm = 1'b0;
        hold_left = 0;
        repeat (3) step();
    endtask

    task automatic do_reset(input string tag);
        instruction = NOP;
        confirm = 1'b0;
        hold_left = 0;
        #1 reset = 1'b0;
        #1;
        disp_model = 32'd0;
        expect_outs({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".rst.wdata"}, rf_wdata, 32'd0);
        chk({tag, ".rst.waddr"}, {27'd0, rf_waddr}, 32'd10);
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Runs one ecall; for exit it returns right after entering the halted state.
    task automatic run_service(input string tag, input logic [31:0] code, input logic [31:0] a0v,
                               input logic [15:0] swv, input int wait_n, input int hold_n);
        logic svc;
        logic is_print;
        logic is_read;
        svc      = (code == 32'd1) || (code == 32'd5) || (code == 32'd10);
        is_print = (code == 32'd1);
        is_read  = (code == 32'd5);
        wen_seen = 0;
        instruction = ECALL;
        a7 = code;
        a0 = a0v;
        switch_in = swv;
        #1;
        chk({tag, ".cycle0_stall"}, {31'd0, stall}, {31'd0, svc});
        if (!svc) begin
            step();
            expect_outs({tag, ".nop_retired"}, 1'b0, 1'b0, 1'b0, 1'b0);
            instruction = NOP;
            chk({tag, ".nop_wen"}, wen_seen, 0);
            return;
        end
        step();
        if (code == 32'd10) begin
            expect_outs({tag, ".halt_entry"}, 1'b1, 1'b0, 1'b0, 1'b1);
            return;
        end
        if (is_print) disp_model = a0v;
        a0 = $urandom;
        expect_outs({tag, ".entered"}, 1'b1, 1'b0, is_print, 1'b0);
        repeat (wait_n) begin
            step();
            expect_outs({tag, ".waiting"}, 1'b1, 1'b0, is_print, 1'b0);
        end
        confirm = 1'b1;
        hold_left = hold_n;
        step();
        expect_outs({tag, ".sync1"}, 1'b1, 1'b0, is_print, 1'b0);
        step();
        expect_outs({tag, ".sync2"}, 1'b1, 1'b0, is_print, 1'b0);
        step();
        if (is_read) begin
            expect_outs({tag, ".writeback"}, 1'b1, 1'b1, 1'b0, 1'b0);
            chk({tag, ".wdata"}, rf_wdata, {16'd0, swv});
            step();
        end
        expect_outs({tag, ".release"}, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        instruction = NOP;
        #1;
        expect_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".wen_count"}, wen_seen, is_read ? 1 : 0);
        if (is_read) chk({tag, ".x10"}, rf_model[10], {16'd0, swv});
        settle_idle();
    endtask

    initial begin
        logic [31:0] x10_before;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'hDEAD_0000 + i;
        disp_model  = 32'd0;
        reset       = 1'b1;
        instruction = NOP;
        a7          = 32'd0;
        a0          = 32'd0;
        switch_in   = 16'd0;
        confirm     = 1'b0;
        do_reset("init");

        run_service("read_a5", 32'd5, 32'h1234_5678, 16'h00A5, 2, 3);
        run_service("print_neg", 32'd1, 32'hFFFF_FFF6, 16'h7777, 4, 2);
        run_service("read_after_print", 32'd5, 32'h0, 16'hFFFF, 0, 1);
        run_service("noop_a7_7", 32'd7, 32'h0, 16'h0, 0, 0);
        run_service("noop_high_bits", 32'h0001_0005, 32'h0, 16'h0, 0, 0);

        // Button already held when the read starts: no capture until a fresh press.
        confirm = 1'b1;
        repeat (3) step();
        wen_seen = 0;
        instruction = ECALL;
        a7 = 32'd5;
        switch_in = 16'h1111;
        #1 chk("held.cycle0_stall", {31'd0, stall}, 32'd1);
        step();
        repeat (6) begin
            expect_outs("held.waiting", 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        confirm = 1'b0;
        repeat (3) begin
            step();
            expect_outs("held.released", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("held.no_capture", wen_seen, 0);
        switch_in = 16'h5A3C;
        confirm = 1'b1;
        hold_left = 2;
        step();
        step();
        expect_outs("held.sync", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        expect_outs("held.writeback", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("held.wdata", rf_wdata, 32'h0000_5A3C);
        step();
        expect_outs("held.release", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        instruction = NOP;
        chk("held.x10", rf_model[10], 32'h0000_5A3C);
        chk("held.wen_count", wen_seen, 1);
        settle_idle();

        // Reset in the middle of a read, with a press already in the synchronizer.
        x10_before = rf_model[10];
        wen_seen = 0;
        instruction = ECALL;
        a7 = 32'd5;
        switch_in = 16'hBEEF;
        step();
        step();
        expect_outs("rstmid.waiting", 1'b1, 1'b0, 1'b0, 1'b0);
        confirm = 1'b1;
        step();
        do_reset("rstmid");
        repeat (4) begin
            step();
            expect_outs("rstmid.after", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("rstmid.no_write", wen_seen, 0);
        chk("rstmid.x10", rf_model[10], x10_before);
        instruction = ECALL;
        a7 = 32'd5;
        #1 chk("rstmid.idle_probe", {31'd0, stall}, 32'd1);
        instruction = NOP;
        settle_idle();

        // Exit: sticky halt regardless of the button.
        disp_model = 32'd0;
        run_service("print_pre_exit", 32'd1, 32'hCAFE_F00D, 16'h0, 1, 1);
        run_service("exit", 32'd10, 32'h0, 16'h0, 0, 0);
        instruction = NOP;
        for (int i = 0; i < 1000; i++) begin
            confirm = 1'($urandom);
            step();
            expect_outs("halted", 1'b1, 1'b0, 1'b0, 1'b1);
        end
        do_reset("post_halt");

        for (int it = 0; it < 30; it++) begin
            logic [31:0] code;
            int sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 4:    code = 32'd1;
                1, 3:    code = 32'd5;
                2:       code = $urandom;
                default: code = 32'd10;
            endcase
            if (sel == 2 && (code == 32'd1 || code == 32'd5 || code == 32'd10))
                code = code | 32'h0000_0100;
            run_service("rand", code, $urandom, 16'($urandom),
                        int'($urandom_range(0, 5)), int'($urandom_range(1, 4)));
            if (code == 32'd10) begin
                instruction = NOP;
                repeat (int'($urandom_range(1, 8))) begin
                    confirm = 1'($urandom);
                    step();
                    expect_outs("rand.halted", 1'b1, 1'b0, 1'b0, 1'b1);
                end
                do_reset("rand.exit");
                settle_idle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
